// File: rtl/result_display_pkg.sv
// rtl/result_display_pkg.sv - shared types, segment constants and BCD step helper for result_display
package display_pkg;

  typedef enum logic {
    CONV_IDLE  = 1'b0,
    CONV_SHIFT = 1'b1
  } conv_state_t;

  localparam logic [6:0] SEG_BLANK = 7'b1111111;
  localparam logic [6:0] SEG_DASH  = 7'b0111111;
  localparam int         BCD_ITERS = 8;

  // One shift-add-3 iteration on {hundreds, tens, ones, binary}.
  function automatic logic [19:0] shift_step(input logic [19:0] s);
    logic [19:0] t;
    t = s;
    for (int i = 0; i < 3; i++) begin
      if (t[8+4*i +: 4] >= 4'd5) t[8+4*i +: 4] = t[8+4*i +: 4] + 4'd3;
    end
    return {t[18:0], 1'b0};
  endfunction

endpackage

// File: rtl/result_display_if.sv
// rtl/result_display_if.sv - processor-to-display bus with master/slave views
interface result_display_if;
  logic        Halt;
  logic [7:0]  Moutput;
  logic [3:0]  DisplayState;
  logic [11:0] bcd;
  logic        valid;
  logic        busy;
  logic [6:0]  seg;
  logic [3:0]  an;

  modport master (output Halt, Moutput, DisplayState,
                  input  bcd, valid, busy, seg, an);
  modport slave  (input  Halt, Moutput, DisplayState,
                  output bcd, valid, busy, seg, an);
endinterface

// File: rtl/result_display_seg7_decoder.sv
// rtl/result_display_seg7_decoder.sv - combinational hex to active-low {g..a} decoder with dash/blank
module seg7_decoder
  import display_pkg::*;
(
  input  logic [3:0] value,
  input  logic       blank,
  input  logic       dash,
  output logic [6:0] seg
);

  always_comb begin
    seg = SEG_BLANK;
    if (dash) begin
      seg = SEG_DASH;
    end else if (!blank) begin
      case (value)
        4'h0: seg = 7'b1000000;
        4'h1: seg = 7'b1111001;
        4'h2: seg = 7'b0100100;
        4'h3: seg = 7'b0110000;
        4'h4: seg = 7'b0011001;
        4'h5: seg = 7'b0010010;
        4'h6: seg = 7'b0000010;
        4'h7: seg = 7'b1111000;
        4'h8: seg = 7'b0000000;
        4'h9: seg = 7'b0010000;
        4'hA: seg = 7'b0001000;
        4'hB: seg = 7'b0000011;
        4'hC: seg = 7'b1000110;
        4'hD: seg = 7'b0100001;
        4'hE: seg = 7'b0000110;
        default: seg = 7'b0001110;
      endcase
    end
  end

endmodule

// File: rtl/result_display.sv
// rtl/result_display.sv - Halt-triggered binary-to-BCD capture and 4-digit 7-seg scan; RESULT_DISP_LZB_EN enables leading-zero blanking
module result_display
  import display_pkg::*;
#(
  parameter int SCAN_DIV = 50000
) (
  input  logic            clock,
  input  logic            reset,
  result_display_if.slave bus
);

  localparam int CW = (SCAN_DIV > 1) ? $clog2(SCAN_DIV) : 1;
  localparam logic [CW-1:0] CNT_MAX = CW'(SCAN_DIV - 1);

  logic        halt_q, cap_q;
  logic [7:0]  data_q;
  conv_state_t state, state_nxt;
  logic [19:0] sreg, sreg_step;
  logic [3:0]  count;
  logic [11:0] bcd_q;
  logic        valid_q;
  logic        busy_c, last_shift;
  logic [CW-1:0] scan_cnt;
  logic [1:0]  scan_idx;
  logic [3:0]  dig_val;
  logic        dig_blank, dig_dash;
  logic        hund_blank, tens_blank;

  // Capture is registered one stage, so loading happens the edge after the rise is seen.
  always_ff @(posedge clock) begin
    if (reset) begin
      halt_q <= 1'b0;
      cap_q  <= 1'b0;
      data_q <= '0;
    end else begin
      halt_q <= bus.Halt;
      cap_q  <= bus.Halt & ~halt_q;
      data_q <= bus.Moutput;
    end
  end

  always_ff @(posedge clock) begin
    if (reset) state <= CONV_IDLE;
    else       state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      CONV_IDLE:  if (cap_q) state_nxt = CONV_SHIFT;
      CONV_SHIFT: if (!cap_q && last_shift) state_nxt = CONV_IDLE;
      default:    state_nxt = CONV_IDLE;
    endcase
  end

  always_comb begin
    busy_c     = (state == CONV_SHIFT);
    last_shift = (state == CONV_SHIFT) && (count == 4'(BCD_ITERS - 1));
  end

  assign sreg_step = shift_step(sreg);

  // A new capture always wins over a finishing shift, leaving bcd untouched.
  always_ff @(posedge clock) begin
    if (reset) begin
      sreg    <= '0;
      count   <= '0;
      bcd_q   <= '0;
      valid_q <= 1'b0;
    end else if (cap_q) begin
      sreg  <= {12'b0, data_q};
      count <= '0;
    end else if (state == CONV_SHIFT) begin
      sreg  <= sreg_step;
      count <= count + 4'd1;
      if (last_shift) begin
        bcd_q   <= sreg_step[19:8];
        valid_q <= 1'b1;
      end
    end
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      scan_cnt <= '0;
      scan_idx <= '0;
    end else if (scan_cnt == CNT_MAX) begin
      scan_cnt <= '0;
      scan_idx <= scan_idx + 2'd1;
    end else begin
      scan_cnt <= scan_cnt + 1'b1;
    end
  end

`ifdef RESULT_DISP_LZB_EN
  assign hund_blank = (bcd_q[11:8] == 4'd0);
  assign tens_blank = (bcd_q[11:4] == 8'd0);
`else
  assign hund_blank = 1'b0;
  assign tens_blank = 1'b0;
`endif

  always_comb begin
    dig_val   = bcd_q[3:0];
    dig_blank = 1'b0;
    dig_dash  = ~valid_q;
    case (scan_idx)
      2'd3: begin dig_val = bus.DisplayState; dig_dash = 1'b0; end
      2'd2: begin dig_val = bcd_q[11:8]; dig_blank = hund_blank; end
      2'd1: begin dig_val = bcd_q[7:4];  dig_blank = tens_blank; end
      default: ;
    endcase
  end

  seg7_decoder u_dec (
    .value (dig_val),
    .blank (dig_blank),
    .dash  (dig_dash),
    .seg   (bus.seg)
  );

  assign bus.an    = ~(4'b0001 << scan_idx);
  assign bus.bcd   = bcd_q;
  assign bus.valid = valid_q;
  assign bus.busy  = busy_c;

endmodule

// File: tb/tb_result_display.sv
// tb/tb_result_display.sv - directed self-checking bench for result_display with SCAN_DIV=2
module tb_result_display;

  logic clock = 1'b0;
  logic reset = 1'b1;
  int   checks = 0;
  int   errors = 0;

  result_display_if bus();

  result_display #(.SCAN_DIV(2)) dut (
    .clock (clock),
    .reset (reset),
    .bus   (bus.slave)
  );

  always #5 clock = ~clock;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic wait_digit(input int d);
    logic [3:0] want;
    bit found;
    want  = ~(4'b0001 << d);
    found = 0;
    for (int i = 0; i < 16 && !found; i++) begin
      if (bus.an === want) found = 1;
      else @(negedge clock);
    end
    chk("an_digit", {28'b0, bus.an}, {28'b0, want});
  endtask

  task automatic cycles(input int n);
    for (int i = 0; i < n; i++) @(negedge clock);
  endtask

  task automatic convert(input logic [7:0] v);
    bus.Halt = 1'b0;
    @(negedge clock);
    @(negedge clock);
    bus.Moutput = v;
    bus.Halt    = 1'b1;
    cycles(11);
  endtask

  initial begin
    bus.Halt         = 1'b0;
    bus.Moutput      = 8'd0;
    bus.DisplayState = 4'hA;

    // 1. reset state
    cycles(2);
    chk("rst_an",    {28'b0, bus.an},    32'b1110);
    chk("rst_seg",   {25'b0, bus.seg},   32'b0111111);
    chk("rst_valid", {31'b0, bus.valid}, 32'd0);
    chk("rst_busy",  {31'b0, bus.busy},  32'd0);
    chk("rst_bcd",   {20'b0, bus.bcd},   32'h0);
    reset = 1'b0;
    @(negedge clock);

    // 2. convert 255, exact latency
    bus.Moutput = 8'd255;
    bus.Halt    = 1'b1;
    @(negedge clock);
    chk("busy_at_N", {31'b0, bus.busy}, 32'd0);
    for (int i = 0; i < 8; i++) begin
      @(negedge clock);
      chk("busy_window", {31'b0, bus.busy}, 32'd1);
      chk("valid_pending", {31'b0, bus.valid}, 32'd0);
    end
    @(negedge clock);
    chk("bcd_255",   {20'b0, bus.bcd},   32'h255);
    chk("valid_255", {31'b0, bus.valid}, 32'd1);
    chk("busy_done", {31'b0, bus.busy},  32'd0);
    wait_digit(3);
    chk("seg_state_A", {25'b0, bus.seg}, 32'b0001000);
    wait_digit(2);
    chk("seg_hund_2", {25'b0, bus.seg}, 32'b0100100);

    // 3. convert 7, blanking-dependent digits
    convert(8'd7);
    chk("bcd_007", {20'b0, bus.bcd}, 32'h007);
    wait_digit(2);
`ifdef RESULT_DISP_LZB_EN
    chk("seg7_d2", {25'b0, bus.seg}, 32'b1111111);
    wait_digit(1);
    chk("seg7_d1", {25'b0, bus.seg}, 32'b1111111);
`else
    chk("seg7_d2", {25'b0, bus.seg}, 32'b1000000);
    wait_digit(1);
    chk("seg7_d1", {25'b0, bus.seg}, 32'b1000000);
`endif
    wait_digit(0);
    chk("seg7_d0", {25'b0, bus.seg}, 32'b1111000);

    // 4. abort 200 with 42 three cycles later
    bus.Halt = 1'b0;
    @(negedge clock);
    bus.Moutput = 8'd200;
    bus.Halt    = 1'b1;
    @(negedge clock);
    @(negedge clock);
    bus.Halt = 1'b0;
    @(negedge clock);
    bus.Moutput = 8'd42;
    bus.Halt    = 1'b1;
    @(negedge clock);
    chk("abort_busy", {31'b0, bus.busy}, 32'd1);
    cycles(8);
    chk("abort_no_200", {20'b0, bus.bcd}, 32'h007);
    @(negedge clock);
    chk("bcd_042", {20'b0, bus.bcd}, 32'h042);
    chk("busy_042", {31'b0, bus.busy}, 32'd0);

    // 5. held Halt never recaptures
    convert(8'd12);
    chk("bcd_012", {20'b0, bus.bcd}, 32'h012);
    bus.Moutput = 8'd99;
    for (int i = 0; i < 12; i++) begin
      @(negedge clock);
      chk("held_busy", {31'b0, bus.busy}, 32'd0);
    end
    chk("held_bcd", {20'b0, bus.bcd}, 32'h012);

    // 6. reset mid-conversion, then convert 0
    bus.Halt = 1'b0;
    @(negedge clock);
    bus.Moutput = 8'd255;
    bus.Halt    = 1'b1;
    cycles(3);
    chk("pre_rst_busy", {31'b0, bus.busy}, 32'd1);
    reset    = 1'b1;
    bus.Halt = 1'b0;
    @(negedge clock);
    chk("mid_rst_busy",  {31'b0, bus.busy},  32'd0);
    chk("mid_rst_valid", {31'b0, bus.valid}, 32'd0);
    chk("mid_rst_an",    {28'b0, bus.an},    32'b1110);
    chk("mid_rst_bcd",   {20'b0, bus.bcd},   32'h0);
    reset = 1'b0;
    convert(8'd0);
    chk("bcd_000",   {20'b0, bus.bcd},   32'h000);
    chk("valid_000", {31'b0, bus.valid}, 32'd1);
    wait_digit(2);
`ifdef RESULT_DISP_LZB_EN
    chk("seg0_d2", {25'b0, bus.seg}, 32'b1111111);
    wait_digit(1);
    chk("seg0_d1", {25'b0, bus.seg}, 32'b1111111);
`else
    chk("seg0_d2", {25'b0, bus.seg}, 32'b1000000);
    wait_digit(1);
    chk("seg0_d1", {25'b0, bus.seg}, 32'b1000000);
`endif
    wait_digit(0);
    chk("seg0_d0", {25'b0, bus.seg}, 32'b1000000);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
